// File: rtl/regfile_multiport.sv
// Parametrised multi-read-port register file with one write port and asynchronous reads.
// Includes an optional hardwired zero entry, optional write-to-read bypass, and a post-reset clear engine.
module regfile_multiport #(
  parameter int AWL      = 5,
  parameter int DWL      = 32,
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wen,
  input  logic [AWL-1:0]     WA,
  input  logic [DWL-1:0]     WD,
  input  logic [NRP*AWL-1:0] RA,
  output logic [NRP*DWL-1:0] RD,
  output logic               init_busy
);

  localparam int DEPTH = 2 ** AWL;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t         state;
  logic [AWL:0]   clr_cnt;
  logic           user_we;
  logic           mem_we;
  logic [AWL-1:0] mem_wa;
  logic [DWL-1:0] mem_wd;

  assign init_busy = (state == CLEAR);
  assign user_we   = wen && !((ZERO_REG != 0) && (WA == '0));

  // The clear engine owns the write port until every entry has been zeroed.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = WA;
    mem_wd = WD;
    if (state == CLEAR) begin
      mem_we = 1'b1;
      mem_wa = clr_cnt[AWL-1:0];
      mem_wd = '0;
    end else begin
      mem_we = user_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == (AWL + 1)'(DEPTH - 1))
            state <= READY;
        end
        READY: begin
          state   <= READY;
          clr_cnt <= clr_cnt;
        end
        default: begin
          state   <= CLEAR;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  // One LUT-RAM bank per read port, all written identically.
  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic [DWL-1:0] bank [DEPTH];
    logic [AWL-1:0] ra;
    logic [DWL-1:0] rd;

    assign ra = RA[p*AWL +: AWL];

    always_ff @(posedge clk) begin
      if (mem_we)
        bank[mem_wa] <= mem_wd;
    end

    always_comb begin
      rd = '0;
      if (init_busy)
        rd = '0;
      else if ((ZERO_REG != 0) && (ra == '0))
        rd = '0;
      else if ((BYPASS != 0) && wen && (WA == ra))
        rd = WD;
      else
        rd = bank[ra];
    end

    assign RD[p*DWL +: DWL] = rd;
  end

endmodule
